// File: rtl/regfile_sb.sv
// Register file with one write port, two combinational read ports with write bypass,
// and a per-entry busy scoreboard tracking outstanding destinations between issue and writeback.
module regfile_sb #(
   parameter int WIDTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [WIDTH-1:0]  rd_data1,
   output logic              rd_ready1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [WIDTH-1:0]  rd_data2,
   output logic              rd_ready2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              issue_ok,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0]  mem_view [DEPTH];
   logic [DEPTH-1:0]  busy_view;
   logic [ADDR_W:0]   busy_cnt_reg;
   logic [ADDR_W:0]   busy_cnt_next;
   logic              issue_zero;
   logic              issue_ok_int;
   logic              do_set;
   logic              do_clr;
   logic              cnt_inc;
   logic              cnt_dec;
   logic [ADDR_W-1:0] rd_addr_arr [2];

   assign issue_zero   = (ZERO_REG != 0) && (issue_addr == '0);
   assign issue_ok_int = !issue_en || !busy_view[issue_addr] ||
                         (wr_en && (wr_addr == issue_addr)) || issue_zero;
   assign do_set       = issue_en && issue_ok_int && !issue_zero;
   // A writeback to the entry being claimed this cycle does not release it.
   assign do_clr       = wr_en && !(do_set && (issue_addr == wr_addr));

   assign issue_ok = issue_ok_int || !rst;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         localparam logic [ADDR_W-1:0] ENTRY   = ADDR_W'(gi);
         localparam bit                IS_ZERO = (ZERO_REG != 0) && (gi == 0);

         logic [WIDTH-1:0] data_reg;
         logic             busy_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               data_reg <= '0;
            end else if (wr_en && (wr_addr == ENTRY) && !IS_ZERO) begin
               data_reg <= wr_data;
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               busy_reg <= 1'b0;
            end else if (do_set && (issue_addr == ENTRY) && !IS_ZERO) begin
               busy_reg <= 1'b1;
            end else if (wr_en && (wr_addr == ENTRY)) begin
               busy_reg <= 1'b0;
            end
         end

         assign mem_view[gi]  = data_reg;
         assign busy_view[gi] = busy_reg;
      end
   endgenerate

   // Count only real transitions so the counter always equals the number of busy bits.
   assign cnt_inc       = do_set && !busy_view[issue_addr];
   assign cnt_dec       = do_clr && busy_view[wr_addr];
   assign busy_cnt_next = busy_cnt_reg + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_cnt_reg <= '0;
      end else begin
         busy_cnt_reg <= busy_cnt_next;
      end
   end

   assign busy_cnt = busy_cnt_reg;

   assign rd_addr_arr[0] = rd_addr1;
   assign rd_addr_arr[1] = rd_addr2;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic             zero_hit;
         logic             wr_hit;
         logic [WIDTH-1:0] port_data;
         logic             port_ready;

         assign zero_hit = (ZERO_REG != 0) && (rd_addr_arr[gi] == '0);
         assign wr_hit   = (BYPASS != 0) && wr_en && (wr_addr == rd_addr_arr[gi]);

         always_comb begin
            port_data  = mem_view[rd_addr_arr[gi]];
            port_ready = zero_hit || !busy_view[rd_addr_arr[gi]] || wr_hit;
            if (wr_hit) begin
               port_data = wr_data;
            end
            // Reset must also mask the bypass path, not just the cleared storage.
            if (zero_hit || !rst) begin
               port_data = '0;
            end
            if (!rst) begin
               port_ready = 1'b1;
            end
         end
      end
   endgenerate

   assign rd_data1  = g_rd[0].port_data;
   assign rd_ready1 = g_rd[0].port_ready;
   assign rd_data2  = g_rd[1].port_data;
   assign rd_ready2 = g_rd[1].port_ready;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (ZERO_REG=1, BYPASS=1): stimulus pushes expected
// values into a queue, a monitor pops and compares them against the live outputs.
module tb_regfile_sb;

   localparam int SIG_D1  = 0;
   localparam int SIG_D2  = 1;
   localparam int SIG_R1  = 2;
   localparam int SIG_R2  = 3;
   localparam int SIG_OK  = 4;
   localparam int SIG_CNT = 5;

   typedef struct {
      string       tag;
      int          sig;
      logic [15:0] val;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [3:0]  rd_addr1;
   logic [15:0] rd_data1;
   logic        rd_ready1;
   logic [3:0]  rd_addr2;
   logic [15:0] rd_data2;
   logic        rd_ready2;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        issue_en;
   logic [3:0]  issue_addr;
   logic        issue_ok;
   logic [4:0]  busy_cnt;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   event check_ev;

   regfile_sb #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut (
      .clk(clk), .rst(rst),
      .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_ready1(rd_ready1),
      .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rd_ready2(rd_ready2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_en(issue_en), .issue_addr(issue_addr), .issue_ok(issue_ok),
      .busy_cnt(busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] actual_of(int sig);
      case (sig)
         SIG_D1:  return rd_data1;
         SIG_D2:  return rd_data2;
         SIG_R1:  return {15'd0, rd_ready1};
         SIG_R2:  return {15'd0, rd_ready2};
         SIG_OK:  return {15'd0, issue_ok};
         default: return {11'd0, busy_cnt};
      endcase
   endfunction

   // Monitor: compares everything queued at each falling edge, or on demand mid-cycle.
   initial begin
      exp_t e;
      logic [15:0] act;
      forever begin
         @(negedge clk or check_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = actual_of(e.sig);
            checks++;
            if (act !== e.val) begin
               errors++;
               $display("FAIL %s sig%0d actual=%h required=%h", e.tag, e.sig, act, e.val);
            end else begin
               $display("CHK  %s sig%0d = %h", e.tag, e.sig, act);
            end
         end
      end
   end

   task automatic expect_val(input string tag, input int sig, input logic [15:0] val);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic ie, input logic [3:0] ia,
                        input logic [3:0] a1, input logic [3:0] a2);
      wr_en      = we;
      wr_addr    = wa;
      wr_data    = wd;
      issue_en   = ie;
      issue_addr = ia;
      rd_addr1   = a1;
      rd_addr2   = a2;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd3, 4'd9);
      step();
      expect_val("rst_d1", SIG_D1, 16'h0);
      expect_val("rst_r1", SIG_R1, 16'h1);
      expect_val("rst_ok", SIG_OK, 16'h1);
      expect_val("rst_cnt", SIG_CNT, 16'h0);
      step();
      rst = 1'b1;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd15);

      // 1: every address reads zero and ready after reset
      for (int a = 0; a < 16; a++) begin
         step();
         drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'(a), 4'(15 - a));
         expect_val("t1_d1", SIG_D1, 16'h0);
         expect_val("t1_d2", SIG_D2, 16'h0);
         expect_val("t1_r1", SIG_R1, 16'h1);
         expect_val("t1_r2", SIG_R2, 16'h1);
         expect_val("t1_cnt", SIG_CNT, 16'h0);
      end

      // 2: write bypass then stored read
      step();
      drive(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 4'd5, 4'd5);
      expect_val("t2_byp_d1", SIG_D1, 16'hBEEF);
      expect_val("t2_byp_d2", SIG_D2, 16'hBEEF);
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd5);
      expect_val("t2_mem_d1", SIG_D1, 16'hBEEF);
      expect_val("t2_mem_d2", SIG_D2, 16'hBEEF);

      // 3: issue, WAW rejection, writeback release
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd3, 4'd3);
      expect_val("t3_ok", SIG_OK, 16'h1);
      expect_val("t3_cnt0", SIG_CNT, 16'h0);
      step();
      expect_val("t3_cnt1", SIG_CNT, 16'h1);
      expect_val("t3_busy_r1", SIG_R1, 16'h0);
      expect_val("t3_waw_ok", SIG_OK, 16'h0);
      step();
      drive(1'b1, 4'd3, 16'h0042, 1'b0, 4'd0, 4'd3, 4'd3);
      expect_val("t3_wb_r1", SIG_R1, 16'h1);
      expect_val("t3_wb_d1", SIG_D1, 16'h0042);
      expect_val("t3_wb_r2", SIG_R2, 16'h1);
      expect_val("t3_wb_cnt", SIG_CNT, 16'h1);
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd3, 4'd3);
      expect_val("t3_free_cnt", SIG_CNT, 16'h0);
      expect_val("t3_free_d1", SIG_D1, 16'h0042);

      // 4: same-cycle issue and writeback on a busy entry
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 4'd7, 4'd7);
      expect_val("t4_claim_ok", SIG_OK, 16'h1);
      step();
      drive(1'b1, 4'd7, 16'h1234, 1'b1, 4'd7, 4'd7, 4'd7);
      expect_val("t4_both_ok", SIG_OK, 16'h1);
      expect_val("t4_both_cnt", SIG_CNT, 16'h1);
      expect_val("t4_both_d1", SIG_D1, 16'h1234);
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd7, 4'd7);
      expect_val("t4_after_d1", SIG_D1, 16'h1234);
      expect_val("t4_after_r1", SIG_R1, 16'h0);
      expect_val("t4_after_cnt", SIG_CNT, 16'h1);

      // 5: zero register ignores writes and claims
      step();
      drive(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 4'd0);
      expect_val("t5_d1", SIG_D1, 16'h0);
      expect_val("t5_d2", SIG_D2, 16'h0);
      expect_val("t5_r1", SIG_R1, 16'h1);
      expect_val("t5_ok", SIG_OK, 16'h1);
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
      expect_val("t5_after_d1", SIG_D1, 16'h0);
      expect_val("t5_after_r1", SIG_R1, 16'h1);
      expect_val("t5_after_cnt", SIG_CNT, 16'h1);

      // 6: several claims, then asynchronous reset between edges
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 4'd5, 4'd7);
      expect_val("t6_ok1", SIG_OK, 16'h1);
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 4'd5, 4'd7);
      expect_val("t6_cnt2", SIG_CNT, 16'h2);
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 4'd1, 4'd5);
      expect_val("t6_cnt3", SIG_CNT, 16'h3);
      expect_val("t6_r1_busy", SIG_R1, 16'h0);
      expect_val("t6_d2", SIG_D2, 16'hBEEF);
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 4'd5, 4'd7);
      expect_val("t6_cnt4", SIG_CNT, 16'h4);
      expect_val("t6_waw4", SIG_OK, 16'h0);
      expect_val("t6_pre_d1", SIG_D1, 16'hBEEF);
      expect_val("t6_pre_d2", SIG_D2, 16'h1234);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      expect_val("t6_arst_cnt", SIG_CNT, 16'h0);
      expect_val("t6_arst_d1", SIG_D1, 16'h0);
      expect_val("t6_arst_d2", SIG_D2, 16'h0);
      expect_val("t6_arst_r2", SIG_R2, 16'h1);
      expect_val("t6_arst_ok", SIG_OK, 16'h1);
      -> check_ev;
      step();
      rst = 1'b1;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd7, 4'd4);
      step();
      expect_val("t6_post_cnt", SIG_CNT, 16'h0);
      expect_val("t6_post_r1", SIG_R1, 16'h1);
      expect_val("t6_post_d1", SIG_D1, 16'h0);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
